chan_arbiter: RTL

CHAN_ARBITER -- requirements
Module: chan_arbiter

---
 rtl/chan_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/chan_arbiter.sv
// Round-robin block arbiter: merges framed blocks from NCH channel processors onto one
// 16-bit stream. Define CHAN_ARBITER_TIMEOUT_EN to enable the DATA-stall watchdog.
module chan_arbiter #(
    parameter int NCH    = 16,
    parameter int GAPCYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    req,
    output logic [NCH-1:0]    ack,
    input  logic [16*NCH-1:0] din,
    output logic [15:0]       dout,
    output logic              dvalid,
    input  logic              dready,
    output logic              dlast,
    input  logic [NCH-1:0]    cmask,
    output logic              hdr_err,
    output logic              busy
);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = $clog2(GAPCYC + 2);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAPCYC > 0) ? GAPCYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;

    state_t          state, nxt;
    logic [GW-1:0]   grant, ptr, pick;
    logic            found;
    logic [8:0]      cnt, hdr_cnt;
    logic [CW-1:0]   gap_cnt;
    logic            blk_end;
    logic [15:0]     din_a [NCH];
    logic [15:0]     word;
    logic [NCH-1:0]  elig;
    logic            req_g, space, take, last, discard, fin, force_eop;

    for (genvar k = 0; k < NCH; k++) begin : g_din
        assign din_a[k] = din[16*k +: 16];
    end

    assign word    = din_a[grant];
    assign req_g   = req[grant];
    assign elig    = req & ~cmask;
    // The output register can take a word when empty or being drained this cycle.
    assign space   = !dvalid || dready;
    assign take    = ((state == HDR) || (state == DATA)) && req_g && space;
    assign hdr_cnt = {1'b0, word[7:0]} + {8'd0, word[14]};
    assign last    = (state == HDR) ? (hdr_cnt == 9'd0) : (cnt == 9'd1);
    assign discard = take && (state == HDR) && !word[15];
    assign fin     = take && (discard || last);

    // Round-robin search starting just above the last granted channel.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= NCH; i++) begin
            if (!found && elig[(int'(ptr) + i) % NCH]) begin
                found = 1'b1;
                pick  = GW'((int'(ptr) + i) % NCH);
            end
        end
    end

`ifdef CHAN_ARBITER_TIMEOUT_EN
    logic [7:0] wd;

    always_ff @(posedge clk) begin
        if (reset || take || (state != DATA)) wd <= 8'd0;
        else if (!req_g && (wd != 8'hFF))     wd <= wd + 8'd1;
    end

    assign force_eop = (state == DATA) && !req_g && (wd == 8'hFF) && space;
`else
    assign force_eop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (found) nxt = HDR;
            HDR, DATA: begin
                if (force_eop) nxt = IDLE;
                else if (take) nxt = (GAPCYC == 0) ? (fin ? IDLE : DATA) : GAP;
            end
            GAP: if (gap_cnt == GAP_LAST) nxt = blk_end ? IDLE : DATA;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        ack = '0;
        if (take) ack[grant] = 1'b1;
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant   <= '0;
            ptr     <= GW'(NCH - 1);
            cnt     <= 9'd0;
            gap_cnt <= '0;
            blk_end <= 1'b0;
            dout    <= 16'd0;
            dvalid  <= 1'b0;
            dlast   <= 1'b0;
            hdr_err <= 1'b0;
        end else begin
            hdr_err <= discard || force_eop;
            if ((state == IDLE) && found) grant <= pick;
            if (take) begin
                gap_cnt <= '0;
                blk_end <= fin;
                cnt     <= (state == HDR) ? hdr_cnt : cnt - 9'd1;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + CW'(1);
            end
            if (fin || force_eop) ptr <= grant;
            if (take && !discard) begin
                dout   <= word;
                dvalid <= 1'b1;
                dlast  <= last;
            end else if (force_eop) begin
                dout   <= 16'h7FFF;
                dvalid <= 1'b1;
                dlast  <= 1'b1;
            end else if (dready) begin
                dvalid <= 1'b0;
                dlast  <= 1'b0;
            end
        end
    end

endmodule
